// File: rtl/ch_rst_seq_pkg.sv
// Shared state encoding and width helper for the channel reset sequencer.
package ch_rst_seq_pkg;

  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_RELEASE = 3'd1,
    S_RUN     = 3'd2,
    S_QUIESCE = 3'd3,
    S_PULSE   = 3'd4,
    S_ACK     = 3'd5
  } state_t;

  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ch_rst_seq_prio.sv
// Lowest-set-bit priority encoder: picks the next channel to service.
module lsb_prio_enc #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  vec,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    valid = |vec;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/ch_rst_seq.sv
// Staggered per-channel reset release followed by serialized soft-reset service
// (quiesce, drain wait, reset pulse, ack) for one channel at a time.
module ch_rst_seq
  import ch_rst_seq_pkg::*;
#(
  parameter int C_NUM_CH         = 8,
  parameter int C_STAGGER        = 16,
  parameter int C_SOFT_RST_WIDTH = 32,
  parameter int C_DRAIN_TIMEOUT  = 1024
) (
  input  logic                slowest_sync_clk,
  input  logic                peripheral_reset,
  input  logic [C_NUM_CH-1:0] soft_rst_req,
  input  logic [C_NUM_CH-1:0] ch_idle,
  output logic [C_NUM_CH-1:0] ch_quiesce,
  output logic [C_NUM_CH-1:0] ch_reset,
  output logic [C_NUM_CH-1:0] ch_aresetn,
  output logic [C_NUM_CH-1:0] soft_rst_ack,
  output logic [C_NUM_CH-1:0] drain_timeout,
  output logic                all_ready,
  output logic                busy
);

  localparam int CW = clog2(C_STAGGER + 1);
  localparam int TW = clog2(C_DRAIN_TIMEOUT + 1);
  localparam int PW = clog2(C_SOFT_RST_WIDTH + 1);
  localparam int XW = clog2(C_NUM_CH + 1);
  localparam int SW = (clog2(C_NUM_CH) > 0) ? clog2(C_NUM_CH) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(C_STAGGER - 1);
  localparam logic [TW-1:0] TMR_LAST  = TW'(C_DRAIN_TIMEOUT - 1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(C_SOFT_RST_WIDTH - 1);
  localparam logic [XW-1:0] IDX_LAST  = XW'(C_NUM_CH - 1);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [XW-1:0]         idx_q, idx_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic [C_NUM_CH-1:0]   pending_q, pending_d;
  logic [C_NUM_CH-1:0]   ch_reset_q, ch_reset_d;
  logic [C_NUM_CH-1:0]   ch_aresetn_q;
  logic [C_NUM_CH-1:0]   ch_quiesce_q, ch_quiesce_d;
  logic [C_NUM_CH-1:0]   ack_q, ack_d;
  logic [C_NUM_CH-1:0]   dto_q, dto_d;
  logic                  all_ready_q, all_ready_d;
  logic                  busy_q, busy_d;

  logic                  pend_valid;
  logic [SW-1:0]         pend_idx;
  logic [C_NUM_CH-1:0]   pend_oh, sel_oh, rel_oh, clr_mask;

  lsb_prio_enc #(.N(C_NUM_CH), .IW(SW)) u_prio (
    .vec   (pending_q),
    .valid (pend_valid),
    .idx   (pend_idx)
  );

  // One-hot masks keep every per-channel update a pure bitwise operation.
  always_comb begin
    for (int i = 0; i < C_NUM_CH; i++) begin
      pend_oh[i] = (pend_idx == SW'(i));
      sel_oh[i]  = (sel_q == SW'(i));
      rel_oh[i]  = (idx_q == XW'(i));
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tmr_d        = tmr_q;
    pcnt_d       = pcnt_q;
    idx_d        = idx_q;
    sel_d        = sel_q;
    ch_reset_d   = ch_reset_q;
    ch_quiesce_d = ch_quiesce_q;
    ack_d        = '0;
    dto_d        = dto_q;
    all_ready_d  = all_ready_q;
    busy_d       = busy_q;
    clr_mask     = '0;

    case (state_q)
      S_HOLD: begin
        state_d = S_RELEASE;
        idx_d   = '0;
        cnt_d   = '0;
      end
      S_RELEASE: begin
        if (cnt_q == CNT_LAST) begin
          ch_reset_d = ch_reset_q & ~rel_oh;
          idx_d      = idx_q + 1'b1;
          cnt_d      = '0;
          if (idx_q == IDX_LAST) begin
            all_ready_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = S_RUN;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (pend_valid) begin
          sel_d        = pend_idx;
          ch_quiesce_d = ch_quiesce_q | pend_oh;
          tmr_d        = '0;
          busy_d       = 1'b1;
          clr_mask     = pend_oh;
          state_d      = S_QUIESCE;
        end
      end
      S_QUIESCE: begin
        // A drain completing on the timeout cycle is a clean drain, not a timeout.
        if ((ch_idle & sel_oh) != '0) begin
          ch_reset_d = ch_reset_q | sel_oh;
          pcnt_d     = '0;
          state_d    = S_PULSE;
        end else if (tmr_q == TMR_LAST) begin
          ch_reset_d = ch_reset_q | sel_oh;
          dto_d      = dto_q | sel_oh;
          pcnt_d     = '0;
          state_d    = S_PULSE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_PULSE: begin
        if (pcnt_q == PCNT_LAST) begin
          ch_reset_d   = ch_reset_q & ~sel_oh;
          ch_quiesce_d = ch_quiesce_q & ~sel_oh;
          ack_d        = sel_oh;
          state_d      = S_ACK;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      S_ACK: begin
        busy_d  = 1'b0;
        state_d = S_RUN;
      end
      default: state_d = S_HOLD;
    endcase

    pending_d = (pending_q & ~clr_mask) | soft_rst_req;
  end

  always_ff @(posedge slowest_sync_clk) begin
    if (peripheral_reset) begin
      state_q      <= S_HOLD;
      cnt_q        <= '0;
      tmr_q        <= '0;
      pcnt_q       <= '0;
      idx_q        <= '0;
      sel_q        <= '0;
      pending_q    <= '0;
      ch_reset_q   <= '1;
      ch_aresetn_q <= '0;
      ch_quiesce_q <= '0;
      ack_q        <= '0;
      dto_q        <= '0;
      all_ready_q  <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      sel_q        <= sel_d;
      pending_q    <= pending_d;
      ch_reset_q   <= ch_reset_d;
      ch_aresetn_q <= ~ch_reset_d;
      ch_quiesce_q <= ch_quiesce_d;
      ack_q        <= ack_d;
      dto_q        <= dto_d;
      all_ready_q  <= all_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign ch_quiesce    = ch_quiesce_q;
  assign ch_reset      = ch_reset_q;
  assign ch_aresetn    = ch_aresetn_q;
  assign soft_rst_ack  = ack_q;
  assign drain_timeout = dto_q;
  assign all_ready     = all_ready_q;
  assign busy          = busy_q;

endmodule
